mm_stream_tx: RTL and testbench

Streaming transmitter for the matrix-multiply (MM) input protocol. It holds two operand matrices loaded by a host and sends them as one element stream on `in_data`/`col_end`/`row_end`: matrix 1 in row-major order, then matrix 2. The stream stalls whenever the MM core raises `busy`. The block sits between the host/config bus and the MM core's input port, and replaces the behavioural stimulus driver used at block level.

---
 rtl/mm_stream_tx.sv | 144 ++++++++++++++
 tb/tb_mm_stream_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mm_stream_tx.sv
// Matrix-multiply stream transmitter: streams two host-loaded operand matrices
// (row-major, matrix 1 then matrix 2) with busy backpressure. Optional macro: MM_TX_SHAPECHK_EN.
module mm_stream_tx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic [3:0]        m1_rows,
    input  logic [3:0]        m1_cols,
    input  logic [3:0]        m2_rows,
    input  logic [3:0]        m2_cols,
    input  logic              start,
    input  logic              busy,
    output logic [DATA_W-1:0] in_data,
    output logic              col_end,
    output logic              row_end,
    output logic              tx_active,
    output logic              done,
    output logic              err
);

    // state  | meaning
    // S_IDLE | outputs quiet; buffer writable; waits for start
    // S_SEND | an element is presented; advances when busy is low
    // S_END  | done pulse; returns to S_IDLE
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_END} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last1;
    logic [ADDR_W-1:0] last_all;
    logic [3:0]        col_cnt;
    logic [3:0]        c1_m1;
    logic [3:0]        c2_m1;
    logic              mat_sel;

    logic [7:0]        s1;
    logic [7:0]        s2;
    logic              start_bad;
    logic [ADDR_W-1:0] nxt_idx;
    logic [3:0]        nxt_col;
    logic              nxt_sel;
    logic              nxt_col_end;
    logic              nxt_row_end;

    always_comb begin
        s1 = 8'(m1_rows) * 8'(m1_cols);
        s2 = 8'(m2_rows) * 8'(m2_cols);
        start_bad = (m1_rows == 4'd0) || (m1_cols == 4'd0) ||
                    (m2_rows == 4'd0) || (m2_cols == 4'd0);
`ifdef MM_TX_SHAPECHK_EN
        start_bad = start_bad || (m1_cols != m2_rows);
`endif
        // Look-ahead for the element that follows the one currently presented.
        nxt_idx     = idx + ADDR_W'(1);
        nxt_col     = col_end ? 4'd0 : col_cnt + 4'd1;
        nxt_sel     = mat_sel | row_end;
        nxt_col_end = (nxt_col == (nxt_sel ? c2_m1 : c1_m1));
        nxt_row_end = nxt_sel ? (nxt_idx == last_all) : (nxt_idx == last1);
    end

    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE)
            mem[cfg_addr] <= cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            last1     <= '0;
            last_all  <= '0;
            col_cnt   <= '0;
            c1_m1     <= '0;
            c2_m1     <= '0;
            mat_sel   <= 1'b0;
            in_data   <= '0;
            col_end   <= 1'b0;
            row_end   <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            err <= 1'b1;
                        end else begin
                            state     <= S_SEND;
                            idx       <= '0;
                            col_cnt   <= '0;
                            mat_sel   <= 1'b0;
                            last1     <= ADDR_W'(s1) - ADDR_W'(1);
                            last_all  <= ADDR_W'(s1) + ADDR_W'(s2) - ADDR_W'(1);
                            c1_m1     <= m1_cols - 4'd1;
                            c2_m1     <= m2_cols - 4'd1;
                            in_data   <= mem[0];
                            col_end   <= (m1_cols == 4'd1);
                            row_end   <= (s1 == 8'd1);
                            tx_active <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (!busy) begin
                        if (idx == last_all) begin
                            state     <= S_END;
                            in_data   <= '0;
                            col_end   <= 1'b0;
                            row_end   <= 1'b0;
                            tx_active <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx     <= nxt_idx;
                            col_cnt <= nxt_col;
                            mat_sel <= nxt_sel;
                            in_data <= mem[nxt_idx];
                            col_end <= nxt_col_end;
                            row_end <= nxt_row_end;
                        end
                    end
                end
                S_END: begin
                    state   <= S_IDLE;
                    idx     <= '0;
                    col_cnt <= '0;
                    mat_sel <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_stream_tx.sv
// Directed, table-driven bench for mm_stream_tx: per-element stream checks,
// stalls, rejected starts, ignored mid-stream requests and mid-stream reset.
module tb_mm_stream_tx;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [3:0]        m1_rows, m1_cols, m2_rows, m2_cols;
    logic              start, busy;
    logic [DATA_W-1:0] in_data;
    logic              col_end, row_end, tx_active, done, err;

    mm_stream_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .m1_rows(m1_rows), .m1_cols(m1_cols),
        .m2_rows(m2_rows), .m2_cols(m2_cols), .start(start), .busy(busy),
        .in_data(in_data), .col_end(col_end), .row_end(row_end),
        .tx_active(tx_active), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // {tx_active, done, err, col_end, row_end, in_data}
    logic [12:0] obs;
    assign obs = {tx_active, done, err, col_end, row_end, in_data};

    localparam logic [12:0] OBS_DONE = 13'h0800;
    localparam logic [12:0] OBS_ERR  = 13'h0400;

    typedef struct {
        logic [3:0]  r1, c1, r2, c2;
        int          n;
        logic [15:0] cm, rm;
        int          stall_at, stall_len;
        int          mode;   // 0 plain, 1 mid-send start+cfg_we, 2 reset at elem 7, 3 start in done cycle
        logic        rej;
    } vec_t;

    vec_t        vt [11];
    logic [7:0]  exp_mem [16];
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int e, st, cycles;
        logic bsy;
        @(negedge clk);
        m1_rows = v.r1; m1_cols = v.c1; m2_rows = v.r2; m2_cols = v.c2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.rej) begin
            chk("err_pulse", obs, OBS_ERR);
            @(negedge clk);
            chk("err_idle", obs, '0);
            return;
        end
        e = 0; st = 0; cycles = 0;
        while (e < v.n && cycles < v.n + v.stall_len + 4) begin
            chk("elem", obs, {3'b100, v.cm[e], v.rm[e], exp_mem[e]});
            cycles++;
            bsy = (e == v.stall_at) && (st < v.stall_len);
            busy = bsy;
            if (v.mode == 1 && e == 3) begin
                start = 1'b1;
                m1_rows = 4'd1; m1_cols = 4'd1; m2_rows = 4'd1; m2_cols = 4'd1;
                cfg_we = 1'b1; cfg_addr = 9'd8; cfg_wdata = ~exp_mem[8];
            end
            if (v.mode == 2 && e == 7) begin
                #1 rst_n = 1'b0;
                #1 chk("rst_out", obs, '0);
                @(negedge clk);
                rst_n = 1'b1; busy = 1'b0;
                @(negedge clk);
                chk("rst_idle", obs, '0);
                return;
            end
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0; busy = 1'b0;
            if (bsy) st++;
            else e++;
        end
        chk("len", 13'(cycles), 13'(v.n + v.stall_len));
        chk("done", obs, OBS_DONE);
        busy  = (v.stall_len > 0);
        start = (v.mode == 3);
        @(negedge clk);
        busy = 1'b0; start = 1'b0;
        chk("after_done", obs, '0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        m1_rows = '0; m1_cols = '0; m2_rows = '0; m2_cols = '0;
        start = 1'b0; busy = 1'b0;
        for (int a = 0; a < 16; a++) exp_mem[a] = 8'((a * 37 + 5) % 256);

        //        r1 c1 r2 c2  n   cm       rm       stall  len mode rej
        vt[0]  = '{2, 3, 3, 2, 12, 16'hAA4, 16'h820, -1, 0, 0, 1'b0};
        vt[1]  = '{2, 3, 3, 2, 12, 16'hAA4, 16'h820,  4, 3, 0, 1'b0};
        vt[2]  = '{1, 1, 1, 1,  2, 16'h003, 16'h003, -1, 0, 0, 1'b0};
`ifdef MM_TX_SHAPECHK_EN
        vt[3]  = '{2, 3, 2, 2,  0, 16'h000, 16'h000, -1, 0, 0, 1'b1};
`else
        vt[3]  = '{2, 3, 2, 2, 10, 16'h2A4, 16'h220, -1, 0, 0, 1'b0};
`endif
        vt[4]  = '{3, 1, 1, 4,  7, 16'h047, 16'h044, -1, 0, 0, 1'b0};
        vt[5]  = '{2, 3, 3, 0,  0, 16'h000, 16'h000, -1, 0, 0, 1'b1};
        vt[6]  = '{0, 5, 5, 2,  0, 16'h000, 16'h000, -1, 0, 0, 1'b1};
        vt[7]  = '{2, 3, 3, 2, 12, 16'hAA4, 16'h820, -1, 0, 1, 1'b0};
        vt[8]  = '{1, 1, 1, 1,  2, 16'h003, 16'h003, -1, 0, 3, 1'b0};
        vt[9]  = '{2, 3, 3, 2, 12, 16'hAA4, 16'h820, -1, 0, 2, 1'b0};
        vt[10] = '{2, 3, 3, 2, 12, 16'hAA4, 16'h820, -1, 0, 0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset", obs, '0);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 9'(a); cfg_wdata = exp_mem[a];
        end
        @(negedge clk);
        cfg_we = 1'b0;
        chk("idle_after_load", obs, '0);

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end
endmodule
